// File: rtl/uart_pkg.sv
// uart_pkg: shared types and default constants for the UART sender slice.
//   uart_state_t      : sender FSM state encoding
//   UART_CLK_PER_BIT  : default clock cycles per serial bit
//   UART_DATA_BITS    : default payload bits per frame
//   UART_STOP_BITS    : default stop bits per frame
// Optional feature macro: UART_SENDER_PARITY_EN (adds the parity state).
package uart_pkg;

    localparam int unsigned UART_CLK_PER_BIT = 31250;
    localparam int unsigned UART_DATA_BITS   = 8;
    localparam int unsigned UART_STOP_BITS   = 1;

    // The ST_ prefix keeps the DATA state distinct from the DATA port.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_SENDER_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } uart_state_t;

endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: bit timer for the UART sender.
//   CLK, RST_N : clock, asynchronous active-low reset
//   en         : count while a frame is in progress, held at 0 otherwise
//   restart    : force the count back to 0 (word acceptance)
//   bit_end    : one-cycle pulse on the last cycle of each serial bit
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = UART_CLK_PER_BIT
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic en,
    input  logic restart,
    output logic bit_end
);

    localparam int unsigned     CNT_W    = $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (restart || !en || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_end = en && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_sender.sv
// uart_sender: valid/ready fed asynchronous serial transmitter.
//   CLK      : system clock, rising edge
//   RST_N    : asynchronous active-low reset
//   DATA     : payload word, captured when VALID && READY
//   VALID    : producer offers DATA
//   READY    : idle and able to accept a word this cycle
//   UART_TX  : registered serial line, idles high
//   BUSY     : a frame is in progress (equals !READY out of reset)
// Frame: start(0), DATA_BITS LSB first, optional even parity, STOP_BITS high.
// Optional feature macro: UART_SENDER_PARITY_EN (even-parity bit).
module uart_sender
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = UART_CLK_PER_BIT,
    parameter int unsigned DATA_BITS   = UART_DATA_BITS,
    parameter int unsigned STOP_BITS   = UART_STOP_BITS
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [DATA_BITS-1:0] DATA,
    input  logic                 VALID,
    output logic                 READY,
    output logic                 UART_TX,
    output logic                 BUSY
);

    localparam int unsigned      IDX_W     = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    if (CLK_PER_BIT < 2) begin : g_bad_clk_per_bit
        $error("uart_sender: CLK_PER_BIT must be 2 or more");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_sender: DATA_BITS must be in 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_sender: STOP_BITS must be 1 or 2");
    end

    uart_state_t          state, state_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [IDX_W-1:0]     idx, idx_n;
    logic                 tx_q, tx_n;
    logic                 armed;
    logic                 restart;
    logic                 bit_end;
`ifdef UART_SENDER_PARITY_EN
    logic                 par_q, par_n;
`endif

    // armed holds READY low until the first edge after reset release.
    assign READY   = armed && (state == ST_IDLE);
    assign BUSY    = (state != ST_IDLE);
    assign UART_TX = tx_q;

    uart_baud_counter #(
        .CLK_PER_BIT(CLK_PER_BIT)
    ) u_baud (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .en      (BUSY),
        .restart (restart),
        .bit_end (bit_end)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
            shreg <= '0;
            idx   <= '0;
            tx_q  <= 1'b1;
            armed <= 1'b0;
`ifdef UART_SENDER_PARITY_EN
            par_q <= 1'b0;
`endif
        end else begin
            state <= state_n;
            shreg <= shreg_n;
            idx   <= idx_n;
            tx_q  <= tx_n;
            armed <= 1'b1;
`ifdef UART_SENDER_PARITY_EN
            par_q <= par_n;
`endif
        end
    end

    // The line value for the next bit is computed here and registered, so
    // tx_q changes exactly on bit boundaries.
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        idx_n   = idx;
        tx_n    = tx_q;
        restart = 1'b0;
`ifdef UART_SENDER_PARITY_EN
        par_n   = par_q;
`endif
        case (state)
            ST_IDLE: begin
                if (VALID && READY) begin
                    state_n = ST_START;
                    shreg_n = DATA;
                    idx_n   = '0;
                    tx_n    = 1'b0;
                    restart = 1'b1;
`ifdef UART_SENDER_PARITY_EN
                    par_n   = ^DATA;
`endif
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_n = ST_DATA;
                    tx_n    = shreg[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (idx == LAST_DATA) begin
                        idx_n   = '0;
`ifdef UART_SENDER_PARITY_EN
                        state_n = ST_PARITY;
                        tx_n    = par_q;
`else
                        state_n = ST_STOP;
                        tx_n    = 1'b1;
`endif
                    end else begin
                        idx_n   = idx + 1'b1;
                        shreg_n = {1'b0, shreg[DATA_BITS-1:1]};
                        tx_n    = shreg[1];
                    end
                end
            end
`ifdef UART_SENDER_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_n = ST_STOP;
                    tx_n    = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    if (idx == LAST_STOP) begin
                        state_n = ST_IDLE;
                        idx_n   = '0;
                    end else begin
                        idx_n   = idx + 1'b1;
                    end
                    tx_n = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                idx_n   = '0;
                tx_n    = 1'b1;
            end
        endcase
    end

endmodule
